// File: rtl/acc_pkg.sv
// Shared types and constants for the accumulator register.
`timescale 1ns/1ps
package acc_pkg;

    localparam int ACC_WIDTH = 11;

    typedef logic [ACC_WIDTH-1:0] acc_word_t;

    localparam acc_word_t ACC_RESET_VAL = '0;

endpackage

// File: rtl/acc_flags.sv
// Zero / negative status flags derived combinationally from the accumulator value.
`timescale 1ns/1ps
module acc_flags
    import acc_pkg::*;
#(
    parameter int WIDTH = ACC_WIDTH
) (
    input  logic [WIDTH-1:0] value,
    output logic             zero,
    output logic             neg
);

    always_comb begin
        zero = (value == '0);
        neg  = value[WIDTH-1];
    end

endmodule

// File: rtl/acumulador_reg.sv
// Accumulator register: synchronous clear, write-enabled load, otherwise hold.
// Optional acc_zero / acc_neg status outputs exist only when ACUMULADOR_FLAGS_EN is defined.
`timescale 1ns/1ps
module acumulador_reg
    import acc_pkg::*;
#(
    parameter int WIDTH = ACC_WIDTH
) (
    input  logic             clock,
    input  logic             acc_reset,
    input  logic [WIDTH-1:0] acc_in,
    input  logic             acc_wr,
`ifdef ACUMULADOR_FLAGS_EN
    output logic             acc_zero,
    output logic             acc_neg,
`endif
    output logic [WIDTH-1:0] acc_out
);

    logic [WIDTH-1:0] acc_d;
    logic [WIDTH-1:0] acc_q;

    always_comb begin
        acc_d = acc_q;
        if (acc_wr) begin
            acc_d = acc_in;
        end
    end

    // No power-on initialiser: the register stays X until the first reset edge.
    always_ff @(posedge clock) begin
        if (acc_reset) begin
            acc_q <= WIDTH'(ACC_RESET_VAL);
        end else begin
            acc_q <= acc_d;
        end
    end

    assign acc_out = acc_q;

`ifdef ACUMULADOR_FLAGS_EN
    acc_flags #(
        .WIDTH (WIDTH)
    ) u_acc_flags (
        .value (acc_q),
        .zero  (acc_zero),
        .neg   (acc_neg)
    );
`endif

endmodule

// File: tb/tb_acumulador_reg.sv
// Scoreboard bench for acumulador_reg: directed vectors push expectations, a monitor checks each cycle.
`timescale 1ns/1ps
module tb_acumulador_reg;

    localparam int W = 11;

    typedef struct {
        logic [W-1:0] acc;
        string        name;
    } exp_t;

    logic         clock;
    logic         acc_reset;
    logic [W-1:0] acc_in;
    logic         acc_wr;
    logic [W-1:0] acc_out;
`ifdef ACUMULADOR_FLAGS_EN
    logic         acc_zero;
    logic         acc_neg;
`endif

    exp_t exp_q[$];
    int   n_vec  = 0;
    int   n_fail = 0;

    acumulador_reg #(.WIDTH(W)) dut (
        .clock     (clock),
        .acc_reset (acc_reset),
        .acc_in    (acc_in),
        .acc_wr    (acc_wr),
`ifdef ACUMULADOR_FLAGS_EN
        .acc_zero  (acc_zero),
        .acc_neg   (acc_neg),
`endif
        .acc_out   (acc_out)
    );

    // Clock source: starts at 0, toggles every 1 ns.
    initial begin
        clock = 1'b0;
        forever #1 clock = ~clock;
    end

    // Monitor: every falling edge follows exactly one capturing rising edge.
    initial begin
        exp_t e;
        forever begin
            @(negedge clock);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                n_vec++;
                if (acc_out !== e.acc) begin
                    n_fail++;
                    $display("FAIL %s acc_out: got %h expected %h", e.name, acc_out, e.acc);
                end
`ifdef ACUMULADOR_FLAGS_EN
                n_vec++;
                if (acc_zero !== (e.acc == '0)) begin
                    n_fail++;
                    $display("FAIL %s acc_zero: got %b expected %b", e.name, acc_zero, (e.acc == '0));
                end
                n_vec++;
                if (acc_neg !== e.acc[W-1]) begin
                    n_fail++;
                    $display("FAIL %s acc_neg: got %b expected %b", e.name, acc_neg, e.acc[W-1]);
                end
`endif
            end
        end
    end

    // Drive one vector shortly after a falling edge so it is captured by the next rising edge.
    // With glitch set, a short reset pulse is issued that ends before that rising edge.
    task automatic apply(input logic rst, input logic wr, input logic [W-1:0] din,
                         input logic glitch, input logic [W-1:0] exp_acc, input string name);
        exp_t e;
        @(negedge clock);
        #0.2;
        acc_reset = rst;
        acc_wr    = wr;
        acc_in    = din;
        e.acc     = exp_acc;
        e.name    = name;
        exp_q.push_back(e);
        if (glitch) begin
            #0.2 acc_reset = 1'b1;
            #0.3 acc_reset = 1'b0;
        end
    endtask

    initial begin
        int guard;
        acc_reset = 1'b0;
        acc_wr    = 1'b0;
        acc_in    = '0;

        apply(1'b1, 1'b0, 11'h123,         1'b0, 11'h000,         "reset");
        apply(1'b0, 1'b1, 11'b00000110010, 1'b0, 11'd50,          "load50");
        apply(1'b0, 1'b0, 11'b00000110010, 1'b0, 11'd50,          "hold50");
        apply(1'b0, 1'b0, 11'b11100000011, 1'b0, 11'd50,          "hold_in_change");
        apply(1'b0, 1'b1, 11'b10110010010, 1'b0, 11'b10110010010, "neg_load");
        apply(1'b0, 1'b0, 11'h000,         1'b0, 11'b10110010010, "neg_hold");
        apply(1'b1, 1'b1, 11'h7FF,         1'b0, 11'h000,         "rst_over_wr");
        apply(1'b0, 1'b1, 11'h7FF,         1'b0, 11'h7FF,         "load_all_ones");
        apply(1'b0, 1'b1, 11'h001,         1'b0, 11'h001,         "b2b_1");
        apply(1'b0, 1'b1, 11'h400,         1'b0, 11'h400,         "b2b_msb");
        apply(1'b0, 1'b0, 11'h155,         1'b1, 11'h400,         "rst_glitch_hold");
        apply(1'b0, 1'b1, 11'h0AA,         1'b1, 11'h0AA,         "rst_glitch_wr");
        apply(1'b1, 1'b0, 11'h3FF,         1'b0, 11'h000,         "rst_span_edge");
        apply(1'b0, 1'b0, 11'h3FF,         1'b0, 11'h000,         "hold_zero");
        apply(1'b0, 1'b1, 11'h2C3,         1'b0, 11'h2C3,         "load_2c3");
        apply(1'b0, 1'b1, 11'h000,         1'b0, 11'h000,         "load_zero");

        guard = 0;
        while (exp_q.size() > 0 && guard < 20) begin
            @(posedge clock);
            guard++;
        end
        if (exp_q.size() > 0) begin
            n_fail++;
            $display("FAIL drain: %0d expectations left unchecked, required 0", exp_q.size());
        end
        @(posedge clock);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
